cam_frame_features: RTL and testbench
=====================================

Name: cam_frame_features

Overview:
- Camera front-end for ML mode of the precision-farming ASIC; sits directly upstream of the harvest classifier.
- Frames VSYNC/HREF-qualified RGB565 byte stream into pixels and accumulates per-frame colour features: pixel count, green-dominant count, brightness sum, row count.
- Emits one-cycle frame_valid with frozen feature registers for the classifier to consume.

Parameters:
- CNT_W, 16, width of pixel_count and green_count (saturating)
- SUM_W, 24, width of bright_sum (saturating)
- ROW_W, 10, width of row_count (saturating)
- GREEN_MARGIN, 4, G5 must exceed R5 by more than this for a green pixel

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- ena  in  1  block enable (ML mode selected); low aborts current frame
- pix_data  in  8  camera byte, valid when href=1
- vsync  in  1  frame active high, already synchronous to clk
- href  in  1  row active high; one byte per clk while high
- pixel_count  out  CNT_W  completed pixels in last frame
- green_count  out  CNT_W  green-dominant pixels in last frame
- bright_sum  out  SUM_W  sum of R5+G5+B5 over last frame
- row_count  out  ROW_W  rows with at least one byte in last frame
- overflow  out  1  any counter saturated in last frame
- frame_valid  out  1  one-cycle pulse, new features on outputs
- busy  out  1  high while in FRAME state

Behaviour:
- Reset: all outputs 0; state WAIT_VS; internal accumulators, byte phase, href_q, vsync_q cleared.
- States: WAIT_VS -> FRAME on vsync rising edge (vsync=1, vsync_q=0) with ena=1; FRAME -> DONE when vsync sampled 0; DONE -> WAIT_VS unconditionally after one cycle.
- Entering FRAME clears all accumulators, phase=0, sticky ovf=0.
- Byte pairing in FRAME: each cycle with href=1, phase=0 stores byte as hi; phase=1 forms pixel {hi,byte}; phase toggles. href=0 forces phase=0 (odd trailing byte dropped, no pixel).
- Pixel decode: R5=hi[7:3], G6={hi[2:0],lo[7:5]}, G5=G6[5:1], B5=lo[4:0].
- Per pixel, on same edge as pair completes: pixel_count+1; bright_sum += R5+G5+B5 (7-bit, zero-extended); green_count+1 iff G5 > R5+GREEN_MARGIN (6-bit compare, no wrap) and G5 >= B5.
- Row: on href falling edge (href_q=1, href=0) in FRAME, row_count+1 if at least one byte arrived in that row.
- Saturation: every accumulator holds at all-ones; any attempted increment past max sets ovf.
- Latency: vsync first sampled 0 in FRAME at edge N -> state DONE; at edge N+1 output registers load accumulators, overflow=ovf, frame_valid=1 for that single cycle (N+1 to N+2). Outputs hold until next frame_valid.
- vsync falling while href=1: pending half pixel discarded, row counted if bytes arrived; no extra pixel.
- Bytes with href=1 outside FRAME ignored.
- busy=1 exactly while state==FRAME.
- ena=0 in any state: next edge -> WAIT_VS, no frame_valid, output registers retain previous frame. New frame requires a fresh vsync rising edge with ena=1 (vsync already high at re-enable is not a start).
- Async reset mid-frame: immediate return to reset values, frame lost.

Test Plan:
- Reset then 10 rows x 40 bytes alternating 0x47,0xF0 inside vsync high -> single frame_valid one cycle after vsync fall; pixel_count=200, green_count=200, row_count=10, bright_sum=11000, overflow=0.
- Same frame with pairs 0xF8,0x1F (R=31,G5=0,B=31) -> pixel_count=200, green_count=0, bright_sum=12400.
- Rows of 41 bytes (odd trailing byte) x 3 rows -> pixel_count=60, row_count=3; trailing bytes produce no pixel.
- Mid-frame ena=0 after 5 rows, then ena=1 with vsync still high -> no frame_valid, outputs keep prior frame, busy=0 until next vsync rise.
- CNT_W=4 with 20 green pixels -> pixel_count=15, green_count=15, overflow=1; next clean 2-pixel frame -> overflow=0.
- href bytes before vsync rise and after vsync fall -> ignored; counts match only in-frame bytes; frame_valid exactly once per frame.

Source files
------------

// File: rtl/cam_frame_features.sv
// Camera front-end: pairs VSYNC/HREF-qualified RGB565 bytes into pixels and
// accumulates per-frame colour features, published with a one-cycle frame_valid.
module cam_frame_features #(
    parameter int CNT_W        = 16,
    parameter int SUM_W        = 24,
    parameter int ROW_W        = 10,
    parameter int GREEN_MARGIN = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic [7:0]       pix_data,
    input  logic             vsync,
    input  logic             href,
    output logic [CNT_W-1:0] pixel_count,
    output logic [CNT_W-1:0] green_count,
    output logic [SUM_W-1:0] bright_sum,
    output logic [ROW_W-1:0] row_count,
    output logic             overflow,
    output logic             frame_valid,
    output logic             busy
);
    // state   | meaning
    // WAIT_VS | idle, waiting for a vsync rising edge while enabled
    // FRAME   | pairing bytes and accumulating features
    // DONE    | accumulators are final; publish them on the next edge
    typedef enum logic [1:0] {WAIT_VS, FRAME, DONE} state_t;

    state_t           r_state, w_state_nxt;
    logic             r_vsync_q, r_href_q, r_phase, r_row_act, r_ovf;
    logic [7:0]       r_hi;
    logic [CNT_W-1:0] r_pix_cnt, r_green_cnt;
    logic [SUM_W-1:0] r_sum;
    logic [ROW_W-1:0] r_row_cnt;

    logic             w_start, w_in_frame, w_byte_en, w_pix_done, w_row_end, w_green;
    logic [4:0]       w_r5, w_g5, w_b5;
    logic [5:0]       w_g6;
    logic [6:0]       w_bright;
    logic [SUM_W:0]   w_sum_ext;

    always_comb begin
        w_state_nxt = r_state;
        if (!ena) begin
            w_state_nxt = WAIT_VS;
        end else begin
            case (r_state)
                WAIT_VS: if (vsync && !r_vsync_q) w_state_nxt = FRAME;
                FRAME:   if (!vsync) w_state_nxt = DONE;
                DONE:    w_state_nxt = WAIT_VS;
                default: w_state_nxt = WAIT_VS;
            endcase
        end
    end

    assign w_start    = (r_state == WAIT_VS) && (w_state_nxt == FRAME);
    assign w_in_frame = (r_state == FRAME) && ena;
    assign w_byte_en  = w_in_frame && vsync && href;
    assign w_pix_done = w_byte_en && r_phase;
    // A row closes on href falling, or when vsync drops with a row still open.
    assign w_row_end  = w_in_frame && r_row_act && ((r_href_q && !href) || !vsync);

    assign w_r5      = r_hi[7:3];
    assign w_g6      = {r_hi[2:0], pix_data[7:5]};
    assign w_g5      = 5'(w_g6 >> 1);
    assign w_b5      = pix_data[4:0];
    assign w_bright  = {2'b00, w_r5} + {2'b00, w_g5} + {2'b00, w_b5};
    assign w_green   = ({1'b0, w_g5} > ({1'b0, w_r5} + 6'(GREEN_MARGIN))) && (w_g5 >= w_b5);
    assign w_sum_ext = {1'b0, r_sum} + {{(SUM_W-6){1'b0}}, w_bright};

    assign busy = (r_state == FRAME);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= WAIT_VS;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vsync_q   <= 1'b0;
            r_href_q    <= 1'b0;
            r_phase     <= 1'b0;
            r_row_act   <= 1'b0;
            r_ovf       <= 1'b0;
            r_hi        <= '0;
            r_pix_cnt   <= '0;
            r_green_cnt <= '0;
            r_sum       <= '0;
            r_row_cnt   <= '0;
        end else begin
            r_vsync_q <= vsync;
            r_href_q  <= href;
            if (w_start) begin
                r_phase     <= 1'b0;
                r_row_act   <= 1'b0;
                r_ovf       <= 1'b0;
                r_hi        <= '0;
                r_pix_cnt   <= '0;
                r_green_cnt <= '0;
                r_sum       <= '0;
                r_row_cnt   <= '0;
            end else if (w_in_frame) begin
                if (w_byte_en) begin
                    r_phase   <= ~r_phase;
                    r_row_act <= 1'b1;
                    if (!r_phase) r_hi <= pix_data;
                end else begin
                    r_phase <= 1'b0;
                end
                if (w_pix_done) begin
                    if (&r_pix_cnt) r_ovf <= 1'b1;
                    else            r_pix_cnt <= r_pix_cnt + 1'b1;
                    if (w_sum_ext[SUM_W]) begin
                        r_sum <= '1;
                        r_ovf <= 1'b1;
                    end else begin
                        r_sum <= w_sum_ext[SUM_W-1:0];
                    end
                    if (w_green) begin
                        if (&r_green_cnt) r_ovf <= 1'b1;
                        else              r_green_cnt <= r_green_cnt + 1'b1;
                    end
                end
                if (w_row_end) begin
                    r_row_act <= 1'b0;
                    if (&r_row_cnt) r_ovf <= 1'b1;
                    else            r_row_cnt <= r_row_cnt + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pixel_count <= '0;
            green_count <= '0;
            bright_sum  <= '0;
            row_count   <= '0;
            overflow    <= 1'b0;
            frame_valid <= 1'b0;
        end else if ((r_state == DONE) && ena) begin
            pixel_count <= r_pix_cnt;
            green_count <= r_green_cnt;
            bright_sum  <= r_sum;
            row_count   <= r_row_cnt;
            overflow    <= r_ovf;
            frame_valid <= 1'b1;
        end else begin
            frame_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cam_frame_features.sv
// Bench for cam_frame_features: directed frames plus randomized frames checked
// against a pixel-level reference model, on a default and a CNT_W=4 instance.
module tb_cam_frame_features;
    logic        clk = 1'b0;
    logic        rst_n, ena, vsync, href;
    logic [7:0]  pix_data;
    logic [15:0] pc, gc;
    logic [23:0] bs;
    logic [9:0]  rc;
    logic        ovf, fv, busy;
    logic [3:0]  s_pc, s_gc;
    logic [23:0] s_bs;
    logic [9:0]  s_rc;
    logic        s_ovf, s_fv, s_busy;

    int n_checks = 0;
    int n_errors = 0;
    int fv_pulses = 0;
    int s_fv_pulses = 0;

    logic [7:0] fbytes[$];
    int         rlen[$];
    bit         noise, trail;
    longint     m_pix, m_green, m_sum, m_rows;
    int         pulses, s_pulses;
    bit         lat_ok, busy_ok;

    always #5 clk = ~clk;

    cam_frame_features u_dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .pix_data(pix_data), .vsync(vsync), .href(href),
        .pixel_count(pc), .green_count(gc), .bright_sum(bs), .row_count(rc),
        .overflow(ovf), .frame_valid(fv), .busy(busy)
    );

    cam_frame_features #(.CNT_W(4)) u_dut_small (
        .clk(clk), .rst_n(rst_n), .ena(ena), .pix_data(pix_data), .vsync(vsync), .href(href),
        .pixel_count(s_pc), .green_count(s_gc), .bright_sum(s_bs), .row_count(s_rc),
        .overflow(s_ovf), .frame_valid(s_fv), .busy(s_busy)
    );

    always @(negedge clk) begin
        if (fv === 1'b1)   fv_pulses   <= fv_pulses + 1;
        if (s_fv === 1'b1) s_fv_pulses <= s_fv_pulses + 1;
    end

    function automatic longint sat(longint v, int w);
        longint mx = (longint'(1) << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    function automatic bit exp_ovf(int cw);
        longint mx = (longint'(1) << cw) - 1;
        return (m_pix > mx) || (m_green > mx) || (m_sum > 64'hFFFFFF) || (m_rows > 1023);
    endfunction

    task automatic clear_frame();
        fbytes.delete();
        rlen.delete();
    endtask

    task automatic add_pair_row(int len, logic [7:0] a, logic [7:0] b);
        for (int i = 0; i < len; i++) fbytes.push_back((i % 2 == 0) ? a : b);
        rlen.push_back(len);
    endtask

    task automatic add_rand_row(int len);
        for (int i = 0; i < len; i++) fbytes.push_back(8'($urandom));
        rlen.push_back(len);
    endtask

    // Reference: whole RGB565 pixels from byte pairs of each row; odd tail dropped.
    task automatic compute_model();
        int idx = 0;
        logic [15:0] px;
        longint r5, g5, b5;
        m_pix = 0; m_green = 0; m_sum = 0; m_rows = 0;
        foreach (rlen[r]) begin
            if (rlen[r] > 0) m_rows++;
            for (int k = 0; k < rlen[r] / 2; k++) begin
                px = {fbytes[idx + 2*k], fbytes[idx + 2*k + 1]};
                r5 = longint'(px[15:11]);
                g5 = longint'(px[10:6]);
                b5 = longint'(px[4:0]);
                m_pix++;
                m_sum += r5 + g5 + b5;
                if ((g5 > r5 + 4) && (g5 >= b5)) m_green++;
            end
            idx += rlen[r];
        end
    endtask

    task automatic drive_rows(int n, int len);
        repeat (n) begin
            href = 1'b1;
            repeat (len) begin pix_data = 8'($urandom); @(posedge clk); #1; end
            href = 1'b0;
            @(posedge clk); #1;
        end
    endtask

    task automatic drive_frame();
        int idx = 0;
        int p0, sp0, last;
        compute_model();
        p0 = fv_pulses; sp0 = s_fv_pulses;
        lat_ok = 1'b1;
        last = rlen.size() - 1;
        if (noise) begin
            href = 1'b1;
            repeat (4) begin pix_data = 8'($urandom); @(posedge clk); #1; end
            href = 1'b0;
            @(posedge clk); #1;
        end
        vsync = 1'b1;
        @(posedge clk); #1;
        foreach (rlen[r]) begin
            if (rlen[r] > 0) begin
                href = 1'b1;
                for (int b = 0; b < rlen[r]; b++) begin
                    pix_data = fbytes[idx]; idx++;
                    @(posedge clk); #1;
                end
            end
            if (!(trail && r == last && rlen[r] > 0)) begin
                href = 1'b0;
                repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
            end
        end
        busy_ok = (busy === 1'b1);
        vsync = 1'b0;
        pix_data = 8'($urandom);
        @(posedge clk); #1;
        href = 1'b0;
        @(negedge clk); if (fv !== 1'b0) lat_ok = 1'b0;
        @(negedge clk); if (fv !== 1'b1) lat_ok = 1'b0;
        @(posedge clk); #1;
        if (noise) begin
            href = 1'b1;
            repeat (4) begin pix_data = 8'($urandom); @(posedge clk); #1; end
            href = 1'b0;
        end
        repeat (3) begin @(posedge clk); #1; end
        pulses = fv_pulses - p0;
        s_pulses = s_fv_pulses - sp0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({pc, gc, bs, rc, ovf, fv, busy} !== '0 || {s_pc, s_gc, s_bs, s_rc, s_ovf, s_fv, s_busy} !== '0) begin
            n_errors++;
            $display("FAIL reset: got pc=%0d gc=%0d sum=%0d rows=%0d ovf=%0b fv=%0b busy=%0b small_busy=%0b, expected all 0",
                     pc, gc, bs, rc, ovf, fv, busy, s_busy);
        end
        @(negedge clk); rst_n = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
    endtask

    task automatic test_green_frame();
        clear_frame();
        repeat (10) add_pair_row(40, 8'h47, 8'hF0);
        drive_frame();
        n_checks++;
        if (!lat_ok || pulses != 1 || !busy_ok) begin
            n_errors++;
            $display("FAIL green_timing: lat_ok=%0b pulses=%0d busy_ok=%0b, expected 1 1 1", lat_ok, pulses, busy_ok);
        end
        n_checks++;
        if ({pc, gc, bs, rc, ovf} !== {16'd200, 16'd200, 24'd11000, 10'd10, 1'b0}) begin
            n_errors++;
            $display("FAIL green_outputs: got %0d/%0d/%0d/%0d/%0b, expected 200/200/11000/10/0", pc, gc, bs, rc, ovf);
        end
    endtask

    task automatic test_magenta_frame();
        clear_frame();
        repeat (10) add_pair_row(40, 8'hF8, 8'h1F);
        drive_frame();
        n_checks++;
        if (!lat_ok || pulses != 1) begin
            n_errors++;
            $display("FAIL magenta_timing: lat_ok=%0b pulses=%0d, expected 1 1", lat_ok, pulses);
        end
        n_checks++;
        if ({pc, gc, bs, rc, ovf} !== {16'd200, 16'd0, 24'd12400, 10'd10, 1'b0}) begin
            n_errors++;
            $display("FAIL magenta_outputs: got %0d/%0d/%0d/%0d/%0b, expected 200/0/12400/10/0", pc, gc, bs, rc, ovf);
        end
    endtask

    task automatic test_odd_bytes();
        clear_frame();
        repeat (3) add_pair_row(41, 8'h47, 8'hF0);
        drive_frame();
        n_checks++;
        if ({pc, gc, bs, rc, ovf} !== {16'd60, 16'd60, 24'd3300, 10'd3, 1'b0} || pulses != 1) begin
            n_errors++;
            $display("FAIL odd_bytes: got %0d/%0d/%0d/%0d/%0b pulses=%0d, expected 60/60/3300/3/0 pulses=1",
                     pc, gc, bs, rc, ovf, pulses);
        end
    endtask

    task automatic test_ena_abort();
        int p0 = fv_pulses;
        vsync = 1'b1;
        @(posedge clk); #1;
        drive_rows(5, 10);
        ena = 1'b0;
        @(posedge clk); #1;
        ena = 1'b1;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) begin
            n_errors++;
            $display("FAIL abort_busy: got busy=%0b after ena drop, expected 0", busy);
        end
        @(posedge clk); #1;
        drive_rows(3, 10);
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) begin
            n_errors++;
            $display("FAIL abort_reenable_busy: got busy=%0b with vsync still high, expected 0", busy);
        end
        @(posedge clk); #1;
        vsync = 1'b0;
        repeat (6) begin @(posedge clk); #1; end
        n_checks++;
        if (fv_pulses != p0) begin
            n_errors++;
            $display("FAIL abort_no_valid: got %0d frame_valid pulses, expected 0", fv_pulses - p0);
        end
        n_checks++;
        if ({pc, gc, bs, rc, ovf} !== {16'd60, 16'd60, 24'd3300, 10'd3, 1'b0}) begin
            n_errors++;
            $display("FAIL abort_hold: got %0d/%0d/%0d/%0d/%0b, expected 60/60/3300/3/0", pc, gc, bs, rc, ovf);
        end
    endtask

    task automatic test_saturation();
        clear_frame();
        repeat (2) add_pair_row(20, 8'h47, 8'hF0);
        drive_frame();
        n_checks++;
        if (!busy_ok || pulses != 1 || s_pulses != 1) begin
            n_errors++;
            $display("FAIL sat_timing: busy_ok=%0b pulses=%0d small_pulses=%0d, expected 1 1 1", busy_ok, pulses, s_pulses);
        end
        n_checks++;
        if ({pc, gc, bs, rc, ovf} !== {16'd20, 16'd20, 24'd1100, 10'd2, 1'b0}) begin
            n_errors++;
            $display("FAIL sat_wide: got %0d/%0d/%0d/%0d/%0b, expected 20/20/1100/2/0", pc, gc, bs, rc, ovf);
        end
        n_checks++;
        if ({s_pc, s_gc, s_bs, s_rc, s_ovf} !== {4'd15, 4'd15, 24'd1100, 10'd2, 1'b1}) begin
            n_errors++;
            $display("FAIL sat_narrow: got %0d/%0d/%0d/%0d/%0b, expected 15/15/1100/2/1", s_pc, s_gc, s_bs, s_rc, s_ovf);
        end
        clear_frame();
        add_pair_row(4, 8'h47, 8'hF0);
        drive_frame();
        n_checks++;
        if ({s_pc, s_gc, s_bs, s_rc, s_ovf} !== {4'd2, 4'd2, 24'd110, 10'd1, 1'b0}) begin
            n_errors++;
            $display("FAIL sat_clear: got %0d/%0d/%0d/%0d/%0b, expected 2/2/110/1/0", s_pc, s_gc, s_bs, s_rc, s_ovf);
        end
    endtask

    task automatic test_out_of_frame();
        clear_frame();
        repeat (4) add_rand_row(12);
        noise = 1'b1;
        drive_frame();
        noise = 1'b0;
        n_checks++;
        if (pulses != 1 || !lat_ok) begin
            n_errors++;
            $display("FAIL oof_timing: pulses=%0d lat_ok=%0b, expected 1 1", pulses, lat_ok);
        end
        n_checks++;
        if ({pc, gc, bs, rc, ovf} !== {16'(m_pix), 16'(m_green), 24'(m_sum), 10'(m_rows), 1'b0}) begin
            n_errors++;
            $display("FAIL oof_outputs: got %0d/%0d/%0d/%0d/%0b, expected %0d/%0d/%0d/%0d/0",
                     pc, gc, bs, rc, ovf, m_pix, m_green, m_sum, m_rows);
        end
    endtask

    task automatic test_async_reset();
        vsync = 1'b1;
        @(posedge clk); #1;
        drive_rows(2, 10);
        href = 1'b1;
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({pc, gc, bs, rc, ovf, fv, busy} !== '0 || {s_pc, s_gc, s_bs, s_rc, s_ovf, s_busy} !== '0) begin
            n_errors++;
            $display("FAIL async_reset: got pc=%0d gc=%0d sum=%0d rows=%0d ovf=%0b busy=%0b, expected all 0",
                     pc, gc, bs, rc, ovf, busy);
        end
        href = 1'b0;
        vsync = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
    endtask

    task automatic test_random();
        for (int f = 0; f < 10; f++) begin
            int nrows;
            clear_frame();
            nrows = $urandom_range(1, 6);
            for (int r = 0; r < nrows; r++) add_rand_row($urandom_range(0, 30));
            noise = 1'($urandom_range(0, 1));
            trail = 1'($urandom_range(0, 1));
            drive_frame();
            n_checks++;
            if (!lat_ok || pulses != 1 || s_pulses != 1) begin
                n_errors++;
                $display("FAIL rand%0d_timing: lat_ok=%0b pulses=%0d small_pulses=%0d, expected 1 1 1",
                         f, lat_ok, pulses, s_pulses);
            end
            n_checks++;
            if ({pc, gc, bs, rc, ovf} !== {16'(sat(m_pix, 16)), 16'(sat(m_green, 16)), 24'(sat(m_sum, 24)),
                                           10'(sat(m_rows, 10)), exp_ovf(16)}) begin
                n_errors++;
                $display("FAIL rand%0d_wide: got %0d/%0d/%0d/%0d/%0b, expected %0d/%0d/%0d/%0d/%0b", f,
                         pc, gc, bs, rc, ovf, m_pix, m_green, m_sum, m_rows, exp_ovf(16));
            end
            n_checks++;
            if ({s_pc, s_gc, s_bs, s_rc, s_ovf} !== {4'(sat(m_pix, 4)), 4'(sat(m_green, 4)), 24'(sat(m_sum, 24)),
                                                     10'(sat(m_rows, 10)), exp_ovf(4)}) begin
                n_errors++;
                $display("FAIL rand%0d_narrow: got %0d/%0d/%0d/%0d/%0b, expected %0d/%0d/%0d/%0d/%0b", f,
                         s_pc, s_gc, s_bs, s_rc, s_ovf, sat(m_pix, 4), sat(m_green, 4), m_sum, m_rows, exp_ovf(4));
            end
        end
        noise = 1'b0;
        trail = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; ena = 1'b1; vsync = 1'b0; href = 1'b0; pix_data = 8'h00;
        noise = 1'b0; trail = 1'b0;
        test_reset();
        test_green_frame();
        test_magenta_frame();
        test_odd_bytes();
        test_ena_abort();
        test_saturation();
        test_out_of_frame();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
